// File: rtl/rs_bank_pkg.sv
// Shared types and helpers for reservation-station banks (rs_bank, LSQ).
// The entry type here is laid out at the default geometry.
package rs_bank_pkg;

  localparam int unsigned RS_NUM_CDB   = 2;
  localparam int unsigned RS_PR_W      = 6;
  localparam int unsigned RS_ROB_W     = 5;
  localparam int unsigned RS_PAYLOAD_W = 128;

  typedef struct packed {
    logic                    busy;
    logic [RS_ROB_W-1:0]     rob_idx;
    logic [RS_PR_W-1:0]      t_idx;
    logic [RS_PR_W-1:0]      t1_idx;
    logic                    t1_ready;
    logic [RS_PR_W-1:0]      t2_idx;
    logic                    t2_ready;
    logic [RS_PAYLOAD_W-1:0] payload;
  } RS_BANK_ENTRY_t;

  localparam RS_BANK_ENTRY_t RS_BANK_ENTRY_RESET = '0;

  // Modulo-2^w distance a - b; callers truncate to their ROB width.
  function automatic int unsigned rob_dist(input int unsigned a, input int unsigned b,
                                           input int unsigned w);
    return (a - b) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Combinational oldest-candidate picker: smallest age among asserted candidates.
// Ages within a bank are unique, so the result is unambiguous.
module rs_age_select #(
  parameter int unsigned N     = 8,
  parameter int unsigned AGE_W = 5,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]            cand_i,
  input  logic [N-1:0][AGE_W-1:0] age_i,
  output logic [N-1:0]            sel_oh_o,
  output logic [IDX_W-1:0]        sel_idx_o,
  output logic                    hit_o
);

  logic             found;
  logic [AGE_W-1:0] best;

  always_comb begin
    found     = 1'b0;
    best      = '0;
    sel_idx_o = '0;
    sel_oh_o  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (cand_i[i] && (!found || (age_i[i] < best))) begin
        found     = 1'b1;
        best      = age_i[i];
        sel_idx_o = IDX_W'(i);
      end
    end
    sel_oh_o[sel_idx_o] = found;
    hit_o               = found;
  end

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station bank: dispatch into the lowest free slot, CDB wakeup,
// oldest-first issue with valid/ready, and ROB-range squash on rollback.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned NUM_CDB     = RS_NUM_CDB,
  parameter int unsigned NUM_PR      = 64,
  parameter int unsigned NUM_ROB     = 32,
  parameter int unsigned PAYLOAD_W   = 128,
  localparam int unsigned PR_W  = $clog2(NUM_PR),
  localparam int unsigned ROB_W = $clog2(NUM_ROB),
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    dispatch_valid_i,
  output logic                    dispatch_ready_o,
  input  logic [PAYLOAD_W-1:0]    dispatch_payload_i,
  input  logic [ROB_W-1:0]        dispatch_rob_idx_i,
  input  logic [PR_W-1:0]         dispatch_t_idx_i,
  input  logic [PR_W-1:0]         dispatch_t1_idx_i,
  input  logic [PR_W-1:0]         dispatch_t2_idx_i,
  input  logic                    dispatch_t1_ready_i,
  input  logic                    dispatch_t2_ready_i,
  input  logic [NUM_CDB-1:0]      cdb_valid_i,
  input  logic [NUM_CDB*PR_W-1:0] cdb_tag_i,
  input  logic [ROB_W-1:0]        rob_head_idx_i,
  input  logic                    rollback_en_i,
  input  logic [ROB_W-1:0]        rollback_rob_idx_i,
  input  logic [ROB_W-1:0]        rollback_diff_i,
  output logic                    issue_valid_o,
  input  logic                    issue_ready_i,
  output logic [PAYLOAD_W-1:0]    issue_payload_o,
  output logic [ROB_W-1:0]        issue_rob_idx_o,
  output logic [PR_W-1:0]         issue_t_idx_o,
  output logic [PR_W-1:0]         issue_t1_idx_o,
  output logic [PR_W-1:0]         issue_t2_idx_o,
  output logic [CNT_W-1:0]        free_count_o
);

  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef struct packed {
    logic                 busy;
    logic [ROB_W-1:0]     rob_idx;
    logic [PR_W-1:0]      t_idx;
    logic [PR_W-1:0]      t1_idx;
    logic                 t1_ready;
    logic [PR_W-1:0]      t2_idx;
    logic                 t2_ready;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;
  logic [CNT_W-1:0]         free_cnt_q, free_cnt_d;

  logic [NUM_ENTRIES-1:0]            t1_eff, t2_eff, squash, cand, sel_oh;
  logic [NUM_ENTRIES-1:0][ROB_W-1:0] age;
  logic [IDX_W-1:0]                  sel_idx, free_idx;
  logic                              sel_hit, free_found;
  logic                              dispatch_fire, issue_fire;
  logic                              disp_t1_hit, disp_t2_hit;
  logic [ROB_W-1:0]                  sq_dist;
  logic [CNT_W-1:0]                  n_squash;
  entry_t                            sel_ent;

  function automatic logic cdb_hit(input logic [NUM_CDB-1:0] v,
                                   input logic [NUM_CDB*PR_W-1:0] tags,
                                   input logic [PR_W-1:0] tag);
    logic h;
    h = 1'b0;
    for (int b = 0; b < int'(NUM_CDB); b++) begin
      if (v[b] && (tags[b*PR_W +: PR_W] == tag)) h = 1'b1;
    end
    return h;
  endfunction

  // Wakeup, squash window and age per entry.
  always_comb begin
    t1_eff   = '0;
    t2_eff   = '0;
    squash   = '0;
    cand     = '0;
    age      = '0;
    sq_dist  = '0;
    n_squash = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      t1_eff[i] = ent_q[i].t1_ready | cdb_hit(cdb_valid_i, cdb_tag_i, ent_q[i].t1_idx);
      t2_eff[i] = ent_q[i].t2_ready | cdb_hit(cdb_valid_i, cdb_tag_i, ent_q[i].t2_idx);
      sq_dist   = ROB_W'(rob_dist(32'(ent_q[i].rob_idx), 32'(rollback_rob_idx_i), ROB_W));
      squash[i] = rollback_en_i && ent_q[i].busy && (sq_dist != '0) &&
                  (sq_dist <= rollback_diff_i);
      cand[i]   = ent_q[i].busy && t1_eff[i] && t2_eff[i] && !squash[i];
      age[i]    = ROB_W'(rob_dist(32'(ent_q[i].rob_idx), 32'(rob_head_idx_i), ROB_W));
      n_squash  = n_squash + CNT_W'(squash[i]);
    end
  end

  rs_age_select #(
    .N     (NUM_ENTRIES),
    .AGE_W (ROB_W)
  ) u_age_select (
    .cand_i    (cand),
    .age_i     (age),
    .sel_oh_o  (sel_oh),
    .sel_idx_o (sel_idx),
    .hit_o     (sel_hit)
  );

  // Lowest-index free slot.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (!ent_q[i].busy && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_ent          = ent_q[sel_idx];
    issue_valid_o    = en_i && sel_hit;
    issue_payload_o  = issue_valid_o ? sel_ent.payload : '0;
    issue_rob_idx_o  = issue_valid_o ? sel_ent.rob_idx : '0;
    issue_t_idx_o    = issue_valid_o ? sel_ent.t_idx   : '0;
    issue_t1_idx_o   = issue_valid_o ? sel_ent.t1_idx  : '0;
    issue_t2_idx_o   = issue_valid_o ? sel_ent.t2_idx  : '0;
    dispatch_ready_o = en_i && !rollback_en_i && (free_cnt_q != '0);
    free_count_o     = free_cnt_q;
    issue_fire       = issue_valid_o && issue_ready_i;
    dispatch_fire    = dispatch_valid_i && dispatch_ready_o && free_found;
    disp_t1_hit      = cdb_hit(cdb_valid_i, cdb_tag_i, dispatch_t1_idx_i);
    disp_t2_hit      = cdb_hit(cdb_valid_i, cdb_tag_i, dispatch_t2_idx_i);
  end

  always_comb begin
    ent_d      = ent_q;
    free_cnt_d = free_cnt_q;
    if (en_i) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (ent_q[i].busy) begin
          ent_d[i].t1_ready = t1_eff[i];
          ent_d[i].t2_ready = t2_eff[i];
          if (squash[i] || (issue_fire && sel_oh[i])) ent_d[i] = '0;
        end
      end
      if (dispatch_fire) begin
        ent_d[free_idx].busy     = 1'b1;
        ent_d[free_idx].rob_idx  = dispatch_rob_idx_i;
        ent_d[free_idx].t_idx    = dispatch_t_idx_i;
        ent_d[free_idx].t1_idx   = dispatch_t1_idx_i;
        ent_d[free_idx].t1_ready = dispatch_t1_ready_i | disp_t1_hit;
        ent_d[free_idx].t2_idx   = dispatch_t2_idx_i;
        ent_d[free_idx].t2_ready = dispatch_t2_ready_i | disp_t2_hit;
        ent_d[free_idx].payload  = dispatch_payload_i;
      end
      free_cnt_d = free_cnt_q - CNT_W'(dispatch_fire) + CNT_W'(issue_fire) + n_squash;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ent_q      <= '0;
      free_cnt_q <= CNT_W'(NUM_ENTRIES);
    end else begin
      ent_q      <= ent_d;
      free_cnt_q <= free_cnt_d;
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Bench for rs_bank: directed scenarios plus random traffic against an
// instruction-list reference model (age and squash from ROB arithmetic).
module tb_rs_bank;

  localparam int N    = 8;
  localparam int NC   = 2;
  localparam int PRW  = 6;
  localparam int ROBW = 5;
  localparam int PW   = 128;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst, en, dv, drdy, dr1, dr2, rbe, iv, ir;
  logic [PW-1:0]   dpay, ipay;
  logic [ROBW-1:0] drob, head, rbi, rbd, irob;
  logic [PRW-1:0]  dt, dt1, dt2, it, it1, it2;
  logic [NC-1:0]   cv;
  logic [NC*PRW-1:0] ct;
  logic [CW-1:0]   fc;

  always #5 clk = ~clk;

  rs_bank dut (
    .clock_i             (clk),
    .reset_i             (rst),
    .en_i                (en),
    .dispatch_valid_i    (dv),
    .dispatch_ready_o    (drdy),
    .dispatch_payload_i  (dpay),
    .dispatch_rob_idx_i  (drob),
    .dispatch_t_idx_i    (dt),
    .dispatch_t1_idx_i   (dt1),
    .dispatch_t2_idx_i   (dt2),
    .dispatch_t1_ready_i (dr1),
    .dispatch_t2_ready_i (dr2),
    .cdb_valid_i         (cv),
    .cdb_tag_i           (ct),
    .rob_head_idx_i      (head),
    .rollback_en_i       (rbe),
    .rollback_rob_idx_i  (rbi),
    .rollback_diff_i     (rbd),
    .issue_valid_o       (iv),
    .issue_ready_i       (ir),
    .issue_payload_o     (ipay),
    .issue_rob_idx_o     (irob),
    .issue_t_idx_o       (it),
    .issue_t1_idx_o      (it1),
    .issue_t2_idx_o      (it2),
    .free_count_o        (fc)
  );

  typedef struct {
    logic [ROBW-1:0] rob;
    logic [PRW-1:0]  t, t1, t2;
    logic            r1, r2;
    logic [PW-1:0]   pay;
  } ins_t;

  ins_t q[$];  // in-bank instructions, dispatch order (q[0] oldest)
  int checks = 0;
  int failures = 0;
  logic [ROBW-1:0] tail;

  function automatic bit hit(input logic [PRW-1:0] tag);
    for (int b = 0; b < NC; b++) if (cv[b] && ct[b*PRW +: PRW] == tag) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs set; checks, clocks, updates the model.
  task automatic cycle();
    bit e1[N], e2[N], sq[N];
    int sel, i_fire, d_fire;
    logic [ROBW-1:0] d, a, best;
    ins_t nq[$];
    ins_t ni;
    #1;
    sel  = -1;
    best = '0;
    for (int i = 0; i < q.size(); i++) begin
      e1[i] = q[i].r1 || hit(q[i].t1);
      e2[i] = q[i].r2 || hit(q[i].t2);
      d     = q[i].rob - rbi;
      sq[i] = rbe && d >= 1 && d <= rbd;
      a     = q[i].rob - head;
      if (e1[i] && e2[i] && !sq[i] && (sel < 0 || a < best)) begin
        sel  = i;
        best = a;
      end
    end
    chk("issue_valid", PW'(iv), PW'(en && sel >= 0));
    if (en && sel >= 0) begin
      chk("issue_rob", PW'(irob), PW'(q[sel].rob));
      chk("issue_t", PW'(it), PW'(q[sel].t));
      chk("issue_t1", PW'(it1), PW'(q[sel].t1));
      chk("issue_t2", PW'(it2), PW'(q[sel].t2));
      chk("issue_payload", ipay, q[sel].pay);
    end
    chk("dispatch_ready", PW'(drdy), PW'(en && !rbe && q.size() < N));
    chk("free_count", PW'(fc), PW'(N - q.size()));
    i_fire = (en && sel >= 0 && ir) ? 1 : 0;
    d_fire = (dv && en && !rbe && q.size() < N) ? 1 : 0;
    ni = '{rob: drob, t: dt, t1: dt1, t2: dt2, r1: dr1 || hit(dt1), r2: dr2 || hit(dt2),
           pay: dpay};
    @(posedge clk);
    if (en) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!(sq[i] || (i_fire != 0 && i == sel))) begin
          nq.push_back(q[i]);
          nq[nq.size()-1].r1 = e1[i];
          nq[nq.size()-1].r2 = e2[i];
        end
      end
      if (d_fire != 0) nq.push_back(ni);
      q = nq;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1'b1; dv = 1'b0; cv = '0; ct = '0; rbe = 1'b0; rbi = '0; rbd = '0; ir = 1'b0;
  endtask

  task automatic set_disp(input logic [ROBW-1:0] rob, input logic [PRW-1:0] t1,
                          input logic r1, input logic [PRW-1:0] t2, input logic r2);
    dv = 1'b1; drob = rob; dt = PRW'($urandom); dt1 = t1; dr1 = r1; dt2 = t2; dr2 = r2;
    dpay = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_issue_valid", PW'(iv), PW'(0));
    chk("reset_free_count", PW'(fc), PW'(N));
    chk("reset_issue_rob", PW'(irob), PW'(0));
    q.delete();
    rst = 1'b0;
  endtask

  initial begin
    logic [ROBW-1:0] span;
    bit acc;
    idle();
    rst = 1'b1; head = '0; drob = '0; dt = '0; dt1 = '0; dt2 = '0; dr1 = 1'b0; dr2 = 1'b0;
    dpay = '0;
    @(negedge clk);
    do_reset();

    // Eight ready instructions, ROB 3..10, issued in ROB order.
    head = 5'd3; ir = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_disp(5'(3 + k), 6'd1, 1'b1, 6'd2, 1'b1);
      cycle();
    end
    dv = 1'b0;
    repeat (2) cycle();
    chk("drain_free_count", PW'(fc), PW'(N));

    // Same-cycle CDB wakeup on bus 1.
    head = 5'd12;
    set_disp(5'd12, 6'd17, 1'b0, 6'd3, 1'b1);
    cycle();
    dv = 1'b0; cycle();
    cv = 2'b10; ct = {6'd17, 6'd0};
    cycle();
    cv = '0; cycle();

    // Fill, then free one: dispatch_ready returns only the following cycle.
    do_reset();
    head = '0; ir = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_disp(5'(k), 6'd20, 1'b0, 6'd21, 1'b1);
      cycle();
    end
    set_disp(5'd8, 6'd1, 1'b1, 6'd2, 1'b1);
    cv = 2'b01; ct = {6'd0, 6'd20};
    cycle();
    cv = '0;
    cycle();
    dv = 1'b0;
    repeat (9) cycle();

    // Wrap-around age: head 30, dispatched out of age order.
    do_reset();
    head = 5'd30; ir = 1'b0;
    set_disp(5'd1, 6'd1, 1'b1, 6'd2, 1'b1); cycle();
    set_disp(5'd0, 6'd1, 1'b1, 6'd2, 1'b1); cycle();
    set_disp(5'd31, 6'd1, 1'b1, 6'd2, 1'b1); cycle();
    dv = 1'b0; ir = 1'b1;
    repeat (4) cycle();

    // ROB-range squash.
    do_reset();
    head = 5'd5;
    for (int k = 0; k < 4; k++) begin
      set_disp(5'(5 + k), 6'd40, 1'b0, 6'd41, 1'b1);
      cycle();
    end
    dv = 1'b0;
    rbe = 1'b1; rbi = 5'd6; rbd = 5'd4;
    cycle();
    rbe = 1'b0;
    cycle();
    chk("squash_free_count", PW'(fc), PW'(6));

    // Asynchronous reset mid-cycle while an issue is held.
    set_disp(5'd6, 6'd1, 1'b1, 6'd2, 1'b1);
    ir = 1'b0;
    cycle();
    dv = 1'b0;
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("async_reset_issue_valid", PW'(iv), PW'(0));
    chk("async_reset_free_count", PW'(fc), PW'(N));
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    idle();
    tail = '0;
    for (int c = 0; c < 500; c++) begin
      head = (q.size() != 0) ? q[0].rob : tail;
      span = tail - head;
      en   = ($urandom % 10) != 0;
      ir   = ($urandom % 4) != 0;
      cv   = NC'($urandom);
      ct   = {6'($urandom % 16), 6'($urandom % 16)};
      rbe  = (q.size() != 0) && (($urandom % 16) == 0);
      if (rbe) begin
        rbi = head + 5'($urandom_range(0, int'(span) - 1));
        rbd = tail - rbi;
      end
      dv = (span < 20) && (($urandom % 3) != 0);
      set_disp(tail, 6'($urandom % 16), 1'($urandom), 6'($urandom % 16), 1'($urandom));
      dv  = dv && (span < 20);
      acc = dv && en && !rbe && q.size() < N;
      cycle();
      if (en && rbe) tail = rbi + 5'd1;
      else if (acc) tail = tail + 5'd1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_bank.md
# rs_bank

Parametrised multi-entry reservation station bank: one instance per functional-unit class, holding up to NUM_ENTRIES renamed instructions between dispatch and FU issue. It replaces the one-entry-per-FU scheme with a multi-entry bank that adds:
- wakeup from NUM_CDB completion buses per cycle;
- oldest-first issue with a valid/ready handshake to the FU;
- ROB-range squash on rollback.

It sits between the dispatch stage (decoder, free list, ROB allocation) and the FU pipeline.

## Interface
Parameters:
- NUM_ENTRIES, 8, bank depth (≥2).
- NUM_CDB, 2, completion buses snooped per cycle.
- NUM_PR, 64, physical registers; PR_W = $clog2(NUM_PR).
- NUM_ROB, 32, ROB entries (power of 2); ROB_W = $clog2(NUM_ROB).
- PAYLOAD_W, 128, opaque payload carried unmodified from dispatch to issue.

Ports:
- clock, in, 1, single clock.
- reset, in, 1, asynchronous, active-high.
- en, in, 1, global stall-low.
- dispatch_valid, in, 1, instruction offered.
- dispatch_ready, out, 1, bank accepts (free_count != 0, en, !rollback_en).
- dispatch_payload, in, PAYLOAD_W, carried fields: inst, func, NPC, dest_idx, FL_idx, T1/T2_select.
- dispatch_ROB_idx, in, ROB_W, ROB slot.
- dispatch_T_idx, in, PR_W, destination tag.
- dispatch_T1_idx, dispatch_T2_idx, in, PR_W each, source tags.
- dispatch_T1_ready, dispatch_T2_ready, in, 1 each, source readiness at dispatch.
- cdb_valid, in, NUM_CDB, per-bus complete strobe.
- cdb_tag, in, NUM_CDB×PR_W, completing tags.
- rob_head_idx, in, ROB_W, oldest ROB slot (age reference).
- rollback_en, in, 1, squash request.
- rollback_ROB_idx, in, ROB_W, mispredicted instruction slot (survives).
- rollback_diff, in, ROB_W, tail − rollback_ROB_idx mod NUM_ROB.
- issue_valid, out, 1, an entry is selected.
- issue_ready, in, 1, FU accepts.
- issue_payload, out, PAYLOAD_W, payload of the selected entry.
- issue_ROB_idx, out, ROB_W, ROB slot of the selected entry.
- issue_T_idx, out, PR_W, destination tag of the selected entry.
- issue_T1_idx, issue_T2_idx, out, PR_W each, source tags of the selected entry.
- free_count, out, $clog2(NUM_ENTRIES+1), registered count of empty entries.

## Operation
- Entry fields: busy, ROB_idx, T_idx, T1{idx,ready}, T2{idx,ready}, payload.
- Wakeup:
  - T*_hit = OR over buses of (cdb_valid[b] && cdb_tag[b]==T*.idx).
  - eff_ready = T*.ready || T*_hit.
  - On each en cycle, eff_ready is written back into T*.ready of every busy entry.
- Dispatch fire = dispatch_valid && dispatch_ready.
  - Writes the lowest-index non-busy entry.
  - Source ready bits = dispatch_T*_ready OR a same-cycle CDB hit on dispatch_T*_idx.
- Candidate = busy && eff_ready(T1) && eff_ready(T2) && !squash.
  - Age = (ROB_idx − rob_head_idx) mod NUM_ROB.
  - The smallest age wins; ROB indices in a bank are unique, so there are no ties.
- Issue fire = issue_valid && issue_ready.
  - The selected entry clears at the next edge.
  - Issue outputs are stable while issue_valid && !issue_ready, unless an older candidate appears, a squash hits, or en drops (no-retention allowed).
- Squash:
  - d = (ROB_idx − rollback_ROB_idx) mod NUM_ROB.
  - Squash when rollback_en && 1 ≤ d ≤ rollback_diff.
  - Squashed entries clear at the next edge and are never presented on issue.
- en low: all state holds; issue_valid=0; dispatch_ready=0.

## Timing
- Reset (async):
  - All busy=0 and free_count=NUM_ENTRIES; issue outputs 0.
  - issue_valid=0 throughout reset, since there are no candidates.
  - dispatch_ready follows its rule once en=1 and rollback_en=0.
- Dispatch-to-issue latency: an instruction dispatched with both sources ready can issue 1 cycle after dispatch. There is no same-cycle bypass.
- CDB-to-issue latency: 0 cycles. An entry woken by a CDB broadcast may issue in the same cycle.
- Full: free_count=0 drops dispatch_ready. An entry freed by issue this cycle is reusable only from the next cycle.
- Simultaneous events:
  - Issue and squash on the same entry: squash wins, and issue_valid excludes it.
  - Dispatch is refused during rollback_en.
- Wrap-around: all age and squash arithmetic is ROB_W-bit unsigned modulo.
- free_count:
  - next = current − dispatch fire + issue fire + number of squashed busy entries.
  - It never exceeds NUM_ENTRIES.
- Reset asserted mid-operation: all entries are lost immediately; no partial state survives.

## Structure
- Shared package:
  - RS_BANK_ENTRY_t (packed entry).
  - ROB-distance function rob_dist(a,b).
  - RS_BANK_ENTRY_RESET constant.
  - NUM_CDB default.
- Sub-module rs_age_select:
  - Inputs: candidate vector and per-entry ages.
  - Outputs: one-hot/indexed oldest plus a hit flag.
  - Combinational, reusable by the LSQ.
- Free-slot finder: a priority encoder inside rs_bank.

## Test plan
- Reset, then dispatch 8 ready instructions with ROB 3..10, issue_ready=1 → issues in ROB order 3,4,…,10 one per cycle; free_count returns to 8.
- Dispatch T1 waiting on tag 17; cdb_valid[1]=1, cdb_tag[1]=17 in cycle N → issue_valid=1 in cycle N with that entry.
- Fill the bank (free_count=0) → dispatch_ready=0. Issue one → dispatch_ready=1 on the next cycle, not the same cycle.
- rob_head_idx=30, entries at ROB 31,0,1 all ready → issue order 31,0,1 (wrap).
- Entries at ROB 5,6,7,8; rollback_en with rollback_ROB_idx=6, rollback_diff=4 → entries 7 and 8 clear, 5 and 6 survive; free_count += 2.
- Hold issue_ready=0 with issue_valid=1, then assert async reset mid-cycle → issue_valid=0 immediately; free_count=8.
